brick_controller: RTL and testbench

Owns the brick field for the breakout display. Holds per-brick alive state and fixed grid positions, and drives the packed brick position buses and alive mask consumed by the colour mapper. Once per video frame it sequentially scans the bricks against the ball's bounding box. On the first overlap it kills that brick, reports a one-cycle hit event with a bounce axis to the ball motion logic, and updates the score.

---
 rtl/brick_if.sv | 39 +++
 rtl/brick_controller.sv | 179 +++++++++++++++++
 tb/tb_brick_controller.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/brick_if.sv
// Signal bundle between the brick controller and its neighbours (ball logic, colour mapper).
interface brick_if #(
  parameter int unsigned NUM_BRICKS = 10
) ();

  // Inputs to the controller
  logic                       frame_clk;
  logic                       level_reset;
  logic [9:0]                 BallX;
  logic [9:0]                 BallY;
  logic [9:0]                 Ball_size;

  // Outputs from the controller
  logic [10*NUM_BRICKS-1:0]   brick_x_vals;
  logic [10*NUM_BRICKS-1:0]   brick_y_vals;
  logic [NUM_BRICKS-1:0]      brick_alive;
  logic                       hit_valid;
  logic [3:0]                 hit_idx;
  logic                       bounce_x;
  logic                       bounce_y;
  logic [7:0]                 score;
  logic                       all_cleared;
  logic                       scan_busy;

  // Ball/game side: drives the ball state and the frame strobe
  modport master (
    output frame_clk, level_reset, BallX, BallY, Ball_size,
    input  brick_x_vals, brick_y_vals, brick_alive, hit_valid, hit_idx,
           bounce_x, bounce_y, score, all_cleared, scan_busy
  );

  // Brick controller side
  modport slave (
    input  frame_clk, level_reset, BallX, BallY, Ball_size,
    output brick_x_vals, brick_y_vals, brick_alive, hit_valid, hit_idx,
           bounce_x, bounce_y, score, all_cleared, scan_busy
  );

endinterface

// File: rtl/brick_controller.sv
// Brick field owner for breakout: per-brick alive state, fixed grid positions, and a
// once-per-frame sequential collision scan of the ball bounding box against the bricks.
module brick_controller #(
  parameter int unsigned NUM_BRICKS = 10,
  parameter int unsigned BRICK_W    = 64,
  parameter int unsigned BRICK_H    = 16,
  parameter int unsigned ROW_X0     = 0,
  parameter int unsigned ROW_Y0     = 40
) (
  input  logic   Clk,
  input  logic   Reset_n,
  brick_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [9:0]              lx_q, ly_q, ls_q;
  logic                    latch_en;
  logic [NUM_BRICKS-1:0]   alive_q, alive_d;
  logic [7:0]              score_q, score_d;
  logic                    hit_valid_q, hit_valid_d;
  logic [3:0]              hit_idx_q, hit_idx_d;
  logic                    bounce_x_q, bounce_x_d;
  logic                    bounce_y_q, bounce_y_d;

  // [0]/[1] synchroniser stages, [2] previous synchronised value for edge detect
  logic [2:0]              sync_q;
  logic                    tick;

  logic [10:0]             lx, ly, ls, bx, by;
  logic                    overlap;
  logic                    x_inside;

  // Fixed brick positions, independent of alive state
  for (genvar i = 0; i < NUM_BRICKS; i++) begin : g_pos
    assign bus.brick_x_vals[10*i +: 10] = 10'(ROW_X0 + 32'(i) * BRICK_W);
    assign bus.brick_y_vals[10*i +: 10] = 10'(ROW_Y0);
  end

  // Bring the frame strobe into the Clk domain and remember its last value
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1], sync_q[0], bus.frame_clk};
    end
  end

  assign tick = sync_q[1] & ~sync_q[2];

  // Overlap test for the brick under scan; all operands widened to 11 bits so that sums
  // cannot wrap and no subtraction (hence no underflow at the screen edge) is needed
  assign lx = {1'b0, lx_q};
  assign ly = {1'b0, ly_q};
  assign ls = {1'b0, ls_q};
  assign bx = 11'(ROW_X0 + 32'(idx_q) * BRICK_W);
  assign by = 11'(ROW_Y0);

  assign overlap = alive_q[idx_q]
                && ((lx + ls) >= bx)
                && (lx < (bx + 11'(BRICK_W) + ls))
                && ((ly + ls) >= by)
                && (ly < (by + 11'(BRICK_H) + ls));

  // Ball centre within the brick's horizontal span means it came from above/below
  assign x_inside = (lx >= bx) && (lx < (bx + 11'(BRICK_W)));

  // Next-state and event logic for the scan FSM
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    alive_d     = alive_q;
    score_d     = score_q;
    hit_valid_d = 1'b0;
    hit_idx_d   = hit_idx_q;
    bounce_x_d  = 1'b0;
    bounce_y_d  = 1'b0;
    latch_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d  = StScan;
          idx_d    = 4'd0;
          latch_en = 1'b1;
        end
      end
      StScan: begin
        if (overlap) begin
          state_d        = StReport;
          alive_d[idx_q] = 1'b0;
          hit_valid_d    = 1'b1;
          hit_idx_d      = idx_q;
          bounce_y_d     = x_inside;
          bounce_x_d     = ~x_inside;
          if (score_q != 8'hFF) begin
            score_d = score_q + 8'd1;
          end
        end else if (idx_q == 4'(NUM_BRICKS - 1)) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StReport: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Level restore overrides everything, including a hit about to be reported and any tick
    if (bus.level_reset) begin
      state_d     = StIdle;
      alive_d     = '1;
      score_d     = score_q;
      hit_valid_d = 1'b0;
      hit_idx_d   = hit_idx_q;
      bounce_x_d  = 1'b0;
      bounce_y_d  = 1'b0;
      latch_en    = 1'b0;
    end
  end

  // FSM state, scan index, brick field and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      idx_q       <= 4'd0;
      alive_q     <= '1;
      score_q     <= 8'd0;
      hit_valid_q <= 1'b0;
      hit_idx_q   <= 4'd0;
      bounce_x_q  <= 1'b0;
      bounce_y_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      alive_q     <= alive_d;
      score_q     <= score_d;
      hit_valid_q <= hit_valid_d;
      hit_idx_q   <= hit_idx_d;
      bounce_x_q  <= bounce_x_d;
      bounce_y_q  <= bounce_y_d;
    end
  end

  // Ball snapshot taken on the frame tick so the scan sees a consistent box
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lx_q <= 10'd0;
      ly_q <= 10'd0;
      ls_q <= 10'd0;
    end else if (latch_en) begin
      lx_q <= bus.BallX;
      ly_q <= bus.BallY;
      ls_q <= bus.Ball_size;
    end
  end

  assign bus.brick_alive = alive_q;
  assign bus.all_cleared = ~|alive_q;
  assign bus.scan_busy   = (state_q != StIdle);
  assign bus.hit_valid   = hit_valid_q;
  assign bus.hit_idx     = hit_idx_q;
  assign bus.bounce_x    = bounce_x_q;
  assign bus.bounce_y    = bounce_y_q;
  assign bus.score       = score_q;

  a_report_one_cycle: assert property (@(posedge Clk) disable iff (!Reset_n)
    (state_q == StReport) |=> (state_q == StIdle));

  a_hit_is_report: assert property (@(posedge Clk) disable iff (!Reset_n)
    hit_valid_q |-> ((state_q == StReport) && (bounce_x_q ^ bounce_y_q)));

endmodule

// File: tb/tb_brick_controller.sv
// Scoreboard bench for brick_controller: directed frames push expected hits, a monitor
// pops and compares whenever hit_valid is presented.
module tb_brick_controller;

  localparam int unsigned NB = 10;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  int   cyc     = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  brick_if #(.NUM_BRICKS(NB)) bus ();

  brick_controller #(.NUM_BRICKS(NB)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  typedef struct {
    int unsigned idx;
    bit          bx;
    bit          by;
    int unsigned score;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          scan_start = 0;
  int unsigned model_score;
  logic [NB-1:0] model_alive;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Monitor: timestamp scan entry, compare every presented hit against the scoreboard
  initial begin : monitor
    exp_t e;
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge Clk);
      if (bus.scan_busy && !prev_busy) scan_start = cyc;
      prev_busy = bus.scan_busy;
      if (bus.hit_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_hit", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("hit_idx", 32'(bus.hit_idx), e.idx);
          check("bounce_x", 32'(bus.bounce_x), 32'(e.bx));
          check("bounce_y", 32'(bus.bounce_y), 32'(e.by));
          check("score_at_hit", 32'(bus.score), e.score);
          check("hit_latency", 32'(cyc - scan_start), e.idx + 1);
          check("alive_cleared_at_hit", 32'(bus.brick_alive[e.idx]), 32'd0);
        end
      end
    end
  end

  task automatic expect_hit(input int unsigned idx, input bit by);
    exp_t e;
    model_score = (model_score == 255) ? 255 : model_score + 1;
    model_alive[idx] = 1'b0;
    e.idx   = idx;
    e.by    = by;
    e.bx    = ~by;
    e.score = model_score;
    sb_q.push_back(e);
  endtask

  // One frame: present the ball, raise frame_clk, count busy cycles, lower frame_clk
  task automatic run_frame(input int unsigned x, input int unsigned y, input int unsigned r,
                           input bit hit, input int unsigned idx, input bit by,
                           output int busy);
    int k;
    @(negedge Clk);
    bus.BallX     = 10'(x);
    bus.BallY     = 10'(y);
    bus.Ball_size = 10'(r);
    if (hit) expect_hit(idx, by);
    bus.frame_clk = 1'b1;
    k = 0;
    while (!bus.scan_busy && k < 10) begin
      @(negedge Clk);
      k++;
    end
    if (!bus.scan_busy) check("scan_start_timeout", 32'd0, 32'd1);
    busy = 0;
    while (bus.scan_busy && busy < 30) begin
      busy++;
      @(negedge Clk);
    end
    bus.frame_clk = 1'b0;
    if (hit) check("sb_drained", 32'(sb_q.size()), 32'd0);
    repeat (3) @(negedge Clk);
  endtask

  task automatic pulse_level_reset();
    @(negedge Clk);
    bus.level_reset = 1'b1;
    @(negedge Clk);
    bus.level_reset = 1'b0;
    model_alive = '1;
  endtask

  initial begin : stimulus
    int busy;
    int k;
    int unsigned clr_list[7];
    clr_list = '{0, 4, 5, 6, 7, 8, 9};
    bus.frame_clk   = 1'b0;
    bus.level_reset = 1'b0;
    bus.BallX       = 10'd0;
    bus.BallY       = 10'd0;
    bus.Ball_size   = 10'd0;
    model_score     = 0;
    model_alive     = '1;

    // Reset then idle
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("rst_alive", 32'(bus.brick_alive), 32'h3FF);
    check("rst_score", 32'(bus.score), 32'd0);
    check("rst_hit_valid", 32'(bus.hit_valid), 32'd0);
    check("rst_hit_idx", 32'(bus.hit_idx), 32'd0);
    check("rst_bounce", 32'({bus.bounce_x, bus.bounce_y}), 32'd0);
    check("rst_scan_busy", 32'(bus.scan_busy), 32'd0);
    check("rst_all_cleared", 32'(bus.all_cleared), 32'd0);
    check("brick3_x", 32'(bus.brick_x_vals[39:30]), 32'd192);
    check("brick3_y", 32'(bus.brick_y_vals[39:30]), 32'd40);
    check("brick0_x", 32'(bus.brick_x_vals[9:0]), 32'd0);
    check("brick9_x", 32'(bus.brick_x_vals[99:90]), 32'd576);
    repeat (20) @(negedge Clk);
    check("idle_scan_busy", 32'(bus.scan_busy), 32'd0);

    // Top hit on brick 3
    run_frame(224, 30, 10, 1'b1, 3, 1'b1, busy);
    check("top_busy_cycles", 32'(busy), 32'd5);
    check("top_alive", 32'(bus.brick_alive), 32'h3F7);
    check("top_score", 32'(bus.score), 32'd1);
    check("top_hit_idx_held", 32'(bus.hit_idx), 32'd3);
    check("top_bounce_cleared", 32'({bus.bounce_x, bus.bounce_y}), 32'd0);

    // Dead brick, then clean miss
    run_frame(224, 30, 10, 1'b0, 0, 1'b0, busy);
    check("dead_busy_cycles", 32'(busy), 32'd10);
    check("dead_score", 32'(bus.score), 32'd1);
    run_frame(300, 300, 5, 1'b0, 0, 1'b0, busy);
    check("miss_busy_cycles", 32'(busy), 32'd10);
    check("miss_alive", 32'(bus.brick_alive), 32'h3F7);

    // Side hit touching bricks 1 and 2: lower index wins, then brick 2 next frame
    run_frame(128, 48, 4, 1'b1, 1, 1'b0, busy);
    check("side_alive", 32'(bus.brick_alive), 32'h3F5);
    check("side_brick2_alive", 32'(bus.brick_alive[2]), 32'd1);
    run_frame(128, 48, 4, 1'b1, 2, 1'b1, busy);
    check("side2_alive", 32'(bus.brick_alive), 32'h3F1);
    check("side2_score", 32'(bus.score), 32'd3);

    // Clear the remaining bricks
    foreach (clr_list[j]) run_frame(clr_list[j] * 64 + 32, 48, 2, 1'b1, clr_list[j], 1'b1, busy);
    check("clear_alive", 32'(bus.brick_alive), 32'h000);
    check("clear_all_cleared", 32'(bus.all_cleared), 32'd1);
    check("clear_score", 32'(bus.score), 32'd10);
    pulse_level_reset();
    check("lvl_alive", 32'(bus.brick_alive), 32'h3FF);
    check("lvl_score_kept", 32'(bus.score), 32'd10);
    check("lvl_all_cleared", 32'(bus.all_cleared), 32'd0);

    // Drive score up to 254, then 3 more hits must saturate at 255
    while (model_score < 254) begin
      run_frame(32, 48, 2, 1'b1, 0, 1'b1, busy);
      pulse_level_reset();
    end
    check("score_254", 32'(bus.score), 32'd254);
    repeat (3) begin
      run_frame(32, 48, 2, 1'b1, 0, 1'b1, busy);
      pulse_level_reset();
    end
    check("score_sat", 32'(bus.score), 32'd255);

    // level_reset in the SCAN cycle that would enter REPORT for brick 3
    @(negedge Clk);
    bus.BallX     = 10'd224;
    bus.BallY     = 10'd30;
    bus.Ball_size = 10'd10;
    bus.frame_clk = 1'b1;
    k = 0;
    while (!bus.scan_busy && k < 10) begin
      @(negedge Clk);
      k++;
    end
    check("lr_scan_started", 32'(bus.scan_busy), 32'd1);
    repeat (3) @(negedge Clk);
    bus.level_reset = 1'b1;
    @(negedge Clk);
    bus.level_reset = 1'b0;
    check("lr_hit_suppressed", 32'(bus.hit_valid), 32'd0);
    check("lr_scan_busy", 32'(bus.scan_busy), 32'd0);
    check("lr_alive", 32'(bus.brick_alive), 32'h3FF);
    check("lr_score", 32'(bus.score), 32'd255);
    bus.frame_clk = 1'b0;
    repeat (6) @(negedge Clk);

    // Async reset while the hit is being reported
    @(negedge Clk);
    expect_hit(3, 1'b1);
    bus.frame_clk = 1'b1;
    k = 0;
    while (bus.hit_valid !== 1'b1 && k < 20) begin
      @(negedge Clk);
      k++;
    end
    check("ar_hit_seen", 32'(bus.hit_valid), 32'd1);
    #2;
    Reset_n       = 1'b0;
    bus.frame_clk = 1'b0;
    #1;
    check("ar_hit_valid", 32'(bus.hit_valid), 32'd0);
    check("ar_score", 32'(bus.score), 32'd0);
    check("ar_alive", 32'(bus.brick_alive), 32'h3FF);
    check("ar_scan_busy", 32'(bus.scan_busy), 32'd0);
    model_score = 0;
    model_alive = '1;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (6) @(negedge Clk);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    check("final_score", 32'(bus.score), 32'(model_score));
    check("final_alive", 32'(bus.brick_alive), 32'(model_alive));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
